// File: rtl/inv_mix_col_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : inv_mix_pkg
//  Purpose  : Shared FSM states and constants for the InvMixColumns unit.
//  Revision : 1.0  initial release
// ============================================================================
package inv_mix_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Indexed M[row][col]; each row is written {c3, c2, c1, c0}
    localparam logic [3:0][3:0][7:0] M = {
        {8'h0e, 8'h09, 8'h0d, 8'h0b},
        {8'h0b, 8'h0e, 8'h09, 8'h0d},
        {8'h0d, 8'h0b, 8'h0e, 8'h09},
        {8'h09, 8'h0d, 8'h0b, 8'h0e}
    };

    localparam logic [7:0] GF_POLY = 8'h1b;

endpackage
`default_nettype wire

// File: rtl/inv_mix_col_unit_if.sv
`default_nettype none
// ============================================================================
//  Module   : inv_mix_col_unit_if
//  Purpose  : Column-in / column-out valid-ready bus for the InvMixColumns unit.
//  Revision : 1.0  initial release
// ============================================================================
interface inv_mix_col_unit_if;

    logic        in_valid;
    logic        in_ready;
    logic [31:0] col_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] col_out;
    logic        busy;

    modport master (
        output in_valid, col_in, out_ready,
        input  in_ready, out_valid, col_out, busy
    );

    modport slave (
        input  in_valid, col_in, out_ready,
        output in_ready, out_valid, col_out, busy
    );

endinterface
`default_nettype wire

// File: rtl/inv_mix_col_unit_gf_mul8.sv
`default_nettype none
// ============================================================================
//  Module   : gf_mul8
//  Purpose  : Combinational GF(2^8) multiply, reduction polynomial 0x11b.
//  Revision : 1.0  initial release
// ============================================================================
module gf_mul8
    import inv_mix_pkg::*;
(
    input  wire logic [7:0] a,
    input  wire logic [7:0] b,
    output logic      [7:0] product
);

    logic [7:0] w_a;
    logic [7:0] w_p;

    // Shift-and-xor: w_a walks through a*x^i, reduced whenever bit 7 falls off
    always_comb begin
        w_a = a;
        w_p = '0;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                w_p = w_p ^ w_a;
            end
            w_a = {w_a[6:0], 1'b0} ^ (w_a[7] ? GF_POLY : 8'h00);
        end
    end

    assign product = w_p;

endmodule
`default_nettype wire

// File: rtl/inv_mix_col_unit.sv
`default_nettype none
// ============================================================================
//  Module   : inv_mix_col_unit
//  Purpose  : AES InvMixColumns on one 32-bit column, one GF product per cycle.
//  Revision : 1.0  initial release
// ============================================================================
module inv_mix_col_unit
    import inv_mix_pkg::*;
(
    input  wire logic          clk,
    input  wire logic          rst,
    inv_mix_col_unit_if.slave  bus
);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [3:0][7:0] r_col;
    logic [3:0][7:0] w_col_nxt;
    logic [3:0][7:0] r_acc;
    logic [3:0][7:0] w_acc_nxt;
    logic [3:0]      r_cnt;
    logic [3:0]      w_cnt_nxt;

    logic [1:0]      w_row;
    logic [1:0]      w_colsel;
    logic [7:0]      w_mul_a;
    logic [7:0]      w_mul_b;
    logic [7:0]      w_prod;

    // cnt walks the matrix row-major: upper bits pick the row, lower the column
    assign w_row    = r_cnt[3:2];
    assign w_colsel = r_cnt[1:0];
    assign w_mul_a  = M[w_row][w_colsel];
    assign w_mul_b  = r_col[w_colsel];

    gf_mul8 u_gf_mul8 (
        .a       (w_mul_a),
        .b       (w_mul_b),
        .product (w_prod)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_col   <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_col   <= w_col_nxt;
            r_acc   <= w_acc_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_col_nxt   = r_col;
        w_acc_nxt   = r_acc;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (bus.in_valid) begin
                    w_state_nxt = CALC;
                    w_col_nxt   = bus.col_in;
                    w_acc_nxt   = '0;
                    w_cnt_nxt   = '0;
                end
            end
            CALC: begin
                w_acc_nxt[w_row] = r_acc[w_row] ^ w_prod;
                w_cnt_nxt        = r_cnt + 4'd1;
                if (r_cnt == 4'd15) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                // Returning to IDLE first keeps a new accept one cycle after the handshake
                if (bus.out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign bus.in_ready  = (r_state == IDLE);
    assign bus.busy      = (r_state == CALC);
    assign bus.out_valid = (r_state == DONE);
    assign bus.col_out   = (r_state == DONE) ? r_acc : 32'h0;

endmodule
`default_nettype wire

// File: tb/tb_inv_mix_col_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_inv_mix_col_unit
//  Purpose  : Directed self-checking bench for inv_mix_col_unit.
//  Revision : 1.0  initial release
// ============================================================================
module tb_inv_mix_col_unit;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    inv_mix_col_unit_if io();

    inv_mix_col_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (io.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst = 1'b1;
        io.in_valid  = 1'b1;
        io.col_in    = 32'hdeadbeef;
        io.out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (io.in_ready !== 1'b1 || io.out_valid !== 1'b0 || io.busy !== 1'b0 || io.col_out !== 32'h0) begin
            failures++;
            $display("FAIL reset_during: in_ready=%b out_valid=%b busy=%b col_out=%h expected 1 0 0 00000000",
                     io.in_ready, io.out_valid, io.busy, io.col_out);
        end
        io.in_valid  = 1'b0;
        io.out_ready = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (io.in_ready !== 1'b1 || io.out_valid !== 1'b0 || io.busy !== 1'b0 || io.col_out !== 32'h0) begin
            failures++;
            $display("FAIL reset_after: in_ready=%b out_valid=%b busy=%b col_out=%h expected 1 0 0 00000000",
                     io.in_ready, io.out_valid, io.busy, io.col_out);
        end
    endtask

    // Accepts one column, checks 16-cycle latency, busy, zeroed col_out, result, then drains
    task automatic test_vector(input logic [31:0] col, input logic [31:0] exp, input string name);
        int lat;
        io.in_valid = 1'b1;
        io.col_in   = col;
        @(negedge clk);
        io.in_valid = 1'b0;
        io.col_in   = 32'h0;
        checks++;
        if (io.busy !== 1'b1 || io.in_ready !== 1'b0 || io.col_out !== 32'h0) begin
            failures++;
            $display("FAIL %s_calc: busy=%b in_ready=%b col_out=%h expected 1 0 00000000",
                     name, io.busy, io.in_ready, io.col_out);
        end
        lat = 0;
        while (io.out_valid !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (lat !== 16) begin
            failures++;
            $display("FAIL %s_latency: got %0d cycles expected 16", name, lat);
        end
        checks++;
        if (io.col_out !== exp) begin
            failures++;
            $display("FAIL %s_result: got %h expected %h", name, io.col_out, exp);
        end
        io.out_ready = 1'b1;
        @(negedge clk);
        io.out_ready = 1'b0;
        checks++;
        if (io.out_valid !== 1'b0 || io.in_ready !== 1'b1 || io.col_out !== 32'h0) begin
            failures++;
            $display("FAIL %s_drain: out_valid=%b in_ready=%b col_out=%h expected 0 1 00000000",
                     name, io.out_valid, io.in_ready, io.col_out);
        end
    endtask

    task automatic test_backpressure();
        int lat;
        int bad;
        io.in_valid = 1'b1;
        io.col_in   = 32'hbca14d8e;
        @(negedge clk);
        io.col_in   = 32'h01010101;
        lat = 0;
        while (io.out_valid !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (io.out_valid !== 1'b1 || io.in_ready !== 1'b0 || io.col_out !== 32'h455313db) bad++;
            @(negedge clk);
        end
        checks++;
        if (bad !== 0 || io.col_out !== 32'h455313db) begin
            failures++;
            $display("FAIL bp_hold: %0d unstable cycles, col_out=%h expected 0 and 455313db", bad, io.col_out);
        end
        io.out_ready = 1'b1;
        @(negedge clk);
        io.out_ready = 1'b0;
        checks++;
        if (io.in_ready !== 1'b1 || io.busy !== 1'b0 || io.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_no_same_edge_accept: in_ready=%b busy=%b out_valid=%b expected 1 0 0",
                     io.in_ready, io.busy, io.out_valid);
        end
        @(negedge clk);
        io.in_valid = 1'b0;
        checks++;
        if (io.busy !== 1'b1) begin
            failures++;
            $display("FAIL bp_second_accept: busy=%b expected 1", io.busy);
        end
        lat = 0;
        while (io.out_valid !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (io.col_out !== 32'h01010101 || lat !== 16) begin
            failures++;
            $display("FAIL bp_second_result: got %h after %0d cycles expected 01010101 after 16", io.col_out, lat);
        end
        io.out_ready = 1'b1;
        @(negedge clk);
        io.out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_calc();
        int seen;
        io.in_valid  = 1'b1;
        io.col_in    = 32'h9d58dc9f;
        @(negedge clk);
        io.in_valid  = 1'b0;
        for (int i = 0; i < 7; i++) @(negedge clk);
        // cnt is now 7; out_ready held high to show it has no effect outside DONE
        io.out_ready = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (io.in_ready !== 1'b1 || io.out_valid !== 1'b0 || io.col_out !== 32'h0 || io.busy !== 1'b0) begin
            failures++;
            $display("FAIL midreset_state: in_ready=%b out_valid=%b col_out=%h busy=%b expected 1 0 00000000 0",
                     io.in_ready, io.out_valid, io.col_out, io.busy);
        end
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (io.out_valid === 1'b1 || io.busy === 1'b1) seen++;
        end
        io.out_ready = 1'b0;
        checks++;
        if (seen !== 0) begin
            failures++;
            $display("FAIL midreset_no_output: got %0d active cycles expected 0", seen);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] cols [2];
        logic [31:0] exps [2];
        logic [31:0] res  [2];
        int          tout [2];
        int          idx;
        int          nout;
        int          cyc;
        logic        pend;
        cols[0] = 32'hbca14d8e; exps[0] = 32'h455313db;
        cols[1] = 32'h9d58dc9f; exps[1] = 32'h5c220af2;
        idx = 0; nout = 0; cyc = 0; pend = 1'b0;
        io.out_ready = 1'b1;
        while (nout < 2 && cyc < 200) begin
            if (io.out_valid === 1'b1) begin
                res[nout]  = io.col_out;
                tout[nout] = cyc;
                nout++;
            end
            if (pend) idx++;
            io.in_valid = (idx < 2);
            io.col_in   = (idx < 2) ? cols[idx] : 32'h0;
            pend        = io.in_valid && io.in_ready;
            @(negedge clk);
            cyc++;
        end
        io.in_valid  = 1'b0;
        io.out_ready = 1'b0;
        checks++;
        if (nout !== 2) begin
            failures++;
            $display("FAIL b2b_count: got %0d results expected 2", nout);
        end else begin
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (res[i] !== exps[i]) begin
                    failures++;
                    $display("FAIL b2b_result%0d: got %h expected %h", i, res[i], exps[i]);
                end
            end
            checks++;
            if (tout[1] - tout[0] < 17) begin
                failures++;
                $display("FAIL b2b_spacing: got %0d cycles expected >= 17", tout[1] - tout[0]);
            end
        end
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        rst          = 1'b1;
        io.in_valid  = 1'b0;
        io.col_in    = 32'h0;
        io.out_ready = 1'b0;
        test_reset();
        test_vector(32'hbca14d8e, 32'h455313db, "case1");
        test_vector(32'h9d58dc9f, 32'h5c220af2, "case2a");
        test_vector(32'h01010101, 32'h01010101, "case2b");
        test_vector(32'h00000000, 32'h00000000, "case2c");
        test_backpressure();
        test_reset_mid_calc();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/inv_mix_col_unit.md
INV_MIX_COL_UNIT -- requirements
Module: inv_mix_col_unit

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high.
REQ-002 Port `clk`: input, 1 bit, rising-edge clock for all state.
REQ-003 Port `rst`: input, 1 bit, synchronous active-high reset.
REQ-004 Port `in_valid`: input, 1 bit, upstream column present on `col_in`.
REQ-005 Port `in_ready`: output, 1 bit, block can accept a column.
REQ-006 Port `col_in`: input, 32 bits, state column; byte r (row r) = bits [8r+7:8r].
REQ-007 Port `out_valid`: output, 1 bit, `col_out` holds a finished result.
REQ-008 Port `out_ready`: input, 1 bit, downstream accepts the result.
REQ-009 Port `col_out`: output, 32 bits, InvMixColumns result column; byte order as `col_in`.
REQ-010 Port `busy`: output, 1 bit, high while in state CALC.

Function
REQ-011 The block SHALL compute col_out row r = XOR over c=0..3 of gfmul(M[r][c], col_in byte c).
- M row 0 = 0e 0b 0d 09; each later row is the previous row rotated right by one.
- gfmul is GF(2^8) multiplication with reduction polynomial 0x11b (xor 0x1b on carry-out).
REQ-012 The block SHALL be a three-state FSM with states IDLE, CALC and DONE.
REQ-013 IDLE: `in_ready`=1; on `in_valid`&&`in_ready` at an edge, register `col_in`, clear the 32-bit accumulator, clear 4-bit counter `cnt`, go to CALC.
REQ-014 CALC: each cycle, with r=cnt[3:2] and c=cnt[1:0], accumulator byte r SHALL be XORed with gfmul(M[r][c], latched byte c), and `cnt` SHALL be incremented.
REQ-015 CALC: at the edge where cnt==15, the block SHALL perform the final accumulate and go to DONE; `cnt` wraps to 0 and SHALL NOT be used again until the next accept.
REQ-016 Latency SHALL be exactly 16 cycles: `out_valid` rises at the 16th rising edge after the accepting edge.
REQ-017 DONE: `out_valid`=1 and `col_out`=accumulator, held stable until `out_valid`&&`out_ready` at an edge; the block then returns to IDLE.
REQ-018 `in_ready` SHALL be 0 in CALC and DONE; `in_valid` there is ignored and the latched column is unaffected.
REQ-019 A new column SHALL be accepted no earlier than one cycle after the output handshake (no same-edge DONE->accept).
REQ-020 `out_ready` asserted outside DONE SHALL have no effect.
REQ-021 `col_out` SHALL read 0 whenever `out_valid`=0.

Reset
REQ-022 When `rst`=1 at an edge, the block SHALL go to IDLE and clear the latched column, accumulator and `cnt` to 0, from any state.
REQ-023 Reset SHALL take priority over every handshake on the same edge.
REQ-024 A reset during CALC or DONE SHALL discard the in-flight result; no `out_valid` pulse follows.
REQ-025 Output values during and immediately after reset SHALL be `in_ready`=1, `out_valid`=0, `busy`=0 and `col_out`=0.

Structure
REQ-026 Package `inv_mix_pkg` SHALL hold:
- the FSM state enum (IDLE/CALC/DONE);
- the 4x4 constant matrix M;
- the constant GF_POLY=8'h1b.
REQ-027 GF multiplication SHALL live in one combinational sub-module `gf_mul8`: 8-bit a, 8-bit b, 8-bit product, iterative shift-and-xor over 8 bits.
REQ-028 Exactly one `gf_mul8` instance SHALL be used, time-multiplexed by `cnt`.

Verification
REQ-029 Case 1: col_in=32'hbca14d8e (8e 4d a1 bc) -> col_out=32'h455313db, with `out_valid` exactly 16 cycles after accept.
REQ-030 Case 2: col_in=32'h9d58dc9f -> col_out=32'h5c220af2; col_in=32'h01010101 -> col_out=32'h01010101; col_in=32'h00000000 -> 32'h00000000.
REQ-031 Case 3 (backpressure): hold `out_ready`=0 for 10 cycles in DONE; `col_out` stays stable, `in_ready`=0, and a second `in_valid` is not accepted until the cycle after the output handshake.
REQ-032 Case 4 (reset mid-CALC): assert `rst` at cnt=7; the next cycle shows `in_ready`=1, `out_valid`=0 and `col_out`=0, and no result is ever emitted for that column.
REQ-033 Case 5 (back-to-back): stream Case 1 then Case 2 columns with `out_ready`=1; check the results in order, 17 cycles apart at minimum.
